// File: rtl/ex_pkg.sv
// Shared types and defaults for the execute stage.
package ex_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_alu_stage_mul_iter.sv
// Iterative shift-add multiplier: latches operands and destination on start,
// retires one multiplier bit per step; done_c flags the final step.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [AW-1:0]   wa_i,
  input  logic            we_i,
  output logic            done_c,
  output logic [XLEN-1:0] product_c,
  output logic [AW-1:0]   wa_o,
  output logic            we_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, addend_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic            we_q, we_d;

  // The final product is the accumulator including the current step's addend.
  always_comb begin
    addend_c  = b_q[0] ? a_q : '0;
    product_c = acc_q + addend_c;
    done_c    = step_i && (cnt_q == CW'(XLEN - 1));
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wa_d      = wa_q;
    we_d      = we_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      wa_d  = wa_i;
      we_d  = we_i;
    end else if (step_i) begin
      acc_d = product_c;
      a_d   = {a_q[XLEN-2:0], 1'b0};
      b_d   = {1'b0, b_q[XLEN-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      wa_q  <= '0;
      we_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wa_q  <= wa_d;
      we_q  <= we_d;
    end
  end

  assign wa_o = wa_q;
  assign we_o = we_q;

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: single-cycle ALU with registered register-file write-back.
// Define EX_ALU_MUL_EN to build in the iterative multiplier (opcode 10).
module ex_alu_stage
  import ex_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [AW-1:0]   in_wa,
  input  logic            in_we,
  output logic            wb_we,
  output logic [AW-1:0]   wb_wa,
  output logic [XLEN-1:0] wb_wd,
  output logic            busy,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  ex_state_e       state_q, state_d;
  logic            wb_we_q, wb_we_d, illegal_q, illegal_d;
  logic [AW-1:0]   wb_wa_q, wb_wa_d;
  logic [XLEN-1:0] wb_wd_q, wb_wd_d, alu_res_c;
  logic [SHW-1:0]  shamt_c;
  logic            op_is_mul_c, op_defined_c;
  logic            mul_done_c, mul_we_c;
  logic [AW-1:0]   mul_wa_c;
  logic [XLEN-1:0] mul_prod_c;

`ifdef EX_ALU_MUL_EN
  logic mul_start_c;

  assign op_is_mul_c = (in_op == OP_MUL);
  assign mul_start_c = (state_q == IDLE) && in_valid && op_is_mul_c;
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == MUL);

  ex_mul_iter #(.XLEN(XLEN), .AW(AW)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start_c),
    .step_i    (state_q == MUL),
    .a_i       (in_a),
    .b_i       (in_b),
    .wa_i      (in_wa),
    .we_i      (in_we),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c),
    .wa_o      (mul_wa_c),
    .we_o      (mul_we_c)
  );
`else
  assign op_is_mul_c = 1'b0;
  assign in_ready    = 1'b1;
  assign busy        = 1'b0;
  assign mul_done_c  = 1'b0;
  assign mul_prod_c  = '0;
  assign mul_wa_c    = '0;
  assign mul_we_c    = 1'b0;
`endif

  assign op_defined_c = (in_op <= 4'd9) || op_is_mul_c;
  assign shamt_c      = in_b[SHW-1:0];

  // Single-cycle ALU datapath.
  always_comb begin
    alu_res_c = '0;
    case (alu_op_e'(in_op))
      OP_ADD:  alu_res_c = in_a + in_b;
      OP_SUB:  alu_res_c = in_a - in_b;
      OP_AND:  alu_res_c = in_a & in_b;
      OP_OR:   alu_res_c = in_a | in_b;
      OP_XOR:  alu_res_c = in_a ^ in_b;
      OP_SLL:  alu_res_c = in_a << shamt_c;
      OP_SRL:  alu_res_c = in_a >> shamt_c;
      OP_SRA:  alu_res_c = XLEN'($signed(in_a) >>> shamt_c);
      OP_SLT:  alu_res_c = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_res_c = XLEN'(in_a < in_b);
      default: alu_res_c = '0;
    endcase
  end

  // Next state and write-back; wa/wd only change when a write is issued.
  always_comb begin
    state_d   = state_q;
    wb_we_d   = 1'b0;
    wb_wa_d   = wb_wa_q;
    wb_wd_d   = wb_wd_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op_is_mul_c) begin
            state_d = MUL;
          end else if (op_defined_c) begin
            if (in_we && (in_wa != '0)) begin
              wb_we_d = 1'b1;
              wb_wa_d = in_wa;
              wb_wd_d = alu_res_c;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          state_d = IDLE;
          if (mul_we_c && (mul_wa_c != '0)) begin
            wb_we_d = 1'b1;
            wb_wa_d = mul_wa_c;
            wb_wd_d = mul_prod_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wb_we_q   <= 1'b0;
      wb_wa_q   <= '0;
      wb_wd_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_we_q   <= wb_we_d;
      wb_wa_q   <= wb_wa_d;
      wb_wd_q   <= wb_wd_d;
      illegal_q <= illegal_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_wa   = wb_wa_q;
  assign wb_wd   = wb_wd_q;
  assign illegal = illegal_q;

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute stage that sits directly downstream of the 32 x 64-bit register file. It consumes the two read operands plus a decoded opcode and destination, and computes a 64-bit result. The result is returned to the register file as a registered one-cycle write (`wb_we`/`wb_wa`/`wb_wd`). Single-cycle ALU ops run at full throughput; an optional iterative multiplier stalls the stage through a valid/ready handshake.

## Interface

- `XLEN`, 64, operand/result width
- `NREG`, 32, number of architectural registers; `AW = $clog2(NREG)` (derived, 5)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  stage can accept; transfer when `in_valid && in_ready` at a rising edge
- `in_op`  in  4  opcode (see Operation)
- `in_a`  in  XLEN  operand A (register file `rd1`)
- `in_b`  in  XLEN  operand B (register file `rd2`)
- `in_wa`  in  AW  destination register address
- `in_we`  in  1  instruction writes a destination
- `wb_we`  out  1  register file write enable, one-cycle pulse
- `wb_wa`  out  AW  register file write address
- `wb_wd`  out  XLEN  register file write data
- `busy`  out  1  multiply in progress
- `illegal`  out  1  one-cycle pulse on an accepted undefined opcode

## Operation

- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low XLEN bits of the product), 11–15 undefined.
- Shifts use `in_b[5:0]` only. ADD, SUB and MUL wrap modulo 2^XLEN, with no flags.
- FSM states: IDLE and MUL. `in_ready = (state == IDLE)`.
- IDLE, accepting a non-MUL op: the result, `wa` and write enable are registered at the same edge. The FSM stays in IDLE.
- IDLE, accepting MUL: operands are latched, a 6-bit step counter is cleared, and the FSM goes to MUL. `busy` is 1.
- MUL: one shift-add step per cycle. After step 64 the product is registered to `wb_*` and the FSM returns to IDLE.
- `wb_we = in_we && (in_wa != 0) && op defined`. Register 0 is never written.
- An undefined op produces no write and pulses `illegal` for one cycle. It costs one cycle, like an ALU op.
- While `in_ready` is 0, `in_valid` is ignored. The upstream stage holds its inputs stable until they are accepted.

## Timing

- Reset values: `wb_we` 0, `wb_wa` 0, `wb_wd` 0, `busy` 0, `illegal` 0, `in_ready` 1, state IDLE, counter 0.
- ALU latency: accepting edge E0 → `wb_*` valid in the cycle after E0. One op per cycle is sustained back to back.
- MUL latency: accepting edge E0, steps at E1..E64, `wb_we` high in the cycle after E64. `in_ready` is low from after E0 until after E64. A new op may be accepted at edge E65.
- `wb_we` and `illegal` are high for exactly one cycle per accepted op. `wb_wa` and `wb_wd` hold their last values otherwise.
- Reset asserted mid-MUL aborts the multiply immediately: no write, `busy` 0, state IDLE.
- No forwarding inside this block. Hazard handling belongs to the issue stage.

## Configuration

- `EX_ALU_MUL_EN` defined: the MUL state and iterative multiplier are compiled in, behaving as above.
- Not defined: opcode 10 is treated as undefined (`illegal` pulse, no write). `busy` is tied to 0 and `in_ready` is tied to 1.

## Structure

- Shared package `ex_pkg`: `alu_op_e` enum (codes 0–10), `ex_state_e` {IDLE, MUL}, constants `XLEN_DEF = 64` and `NREG_DEF = 32`.
- One sub-module, `ex_mul_iter`: operand latch, 64-step shift-add, `start`/`done` handshake with the FSM. It is instantiated only under `EX_ALU_MUL_EN`.

## Test plan

- Reset: hold `rst_n` = 0 → all outputs 0, `in_ready` 1. Release → idle with no `wb_we`.
- Back to back, one per cycle: ADD 5+7 wa=3, SUB 0−1 wa=4, SRA 0x8000_0000_0000_0000>>>4 wa=5 → `wb_wd` = 12, 0xFFFF_FFFF_FFFF_FFFF, 0xF800_0000_0000_0000 on consecutive cycles, with `wb_wa` 3, 4, 5.
- Write suppression: ADD wa=0 `in_we`=1, then ADD wa=7 `in_we`=0 → `wb_we` stays 0 for both. Opcode 13 → `illegal` one-cycle pulse, no write.
- MUL: 0x1_0000_0003 × 0x1_0000_0005 wa=9 → `in_ready` low 64 cycles, then `wb_wd` = 0x0000_0008_0000_000F with `wb_we` high for one cycle. An ADD held on `in_valid` meanwhile is accepted at E65.
- Reset mid-MUL: assert `rst_n` = 0 at step 30 → no `wb_we`, `busy` 0, `in_ready` 1 after release.
- Macro off: MUL op → `illegal` pulse, no write, `in_ready` stays 1.
